// File: rtl/pu_trace_pkg.sv
// pu_trace_pkg: shared types for the write-back trace UART
package pu_trace_pkg;
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
endpackage

// File: rtl/trace_fifo.sv
// trace_fifo: synchronous FIFO, a push is accepted when not full or when a pop happens on the same edge
module trace_fifo #(
   parameter int DW    = 16,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [DW-1:0]            din,
   output logic [DW-1:0]            dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   logic [DW-1:0] r_mem [DEPTH];
   logic [AW-1:0] r_wp, r_rp;
   logic [AW:0]   r_cnt;
   logic          w_push, w_pop;
   assign w_pop  = pop & ~empty;
   assign w_push = push & (~full | w_pop);
   assign empty  = r_cnt == 0;
   assign full   = r_cnt == (AW+1)'(DEPTH);
   assign count  = r_cnt;
   assign dout   = r_mem[r_rp];
   // storage array, no reset needed since entries are only read once written
   always_ff @(posedge clk)
      if (w_push) r_mem[r_wp] <= din;
   // pointers and occupancy, pointers wrap modulo DEPTH
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         r_wp  <= '0;
         r_rp  <= '0;
         r_cnt <= '0;
      end else begin
         if (w_push) r_wp <= r_wp + 1'b1;
         if (w_pop) r_rp <= r_rp + 1'b1;
         r_cnt <= r_cnt + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
      end
endmodule

// File: rtl/wb_trace_uart.sv
// wb_trace_uart: captures register write-backs into a FIFO and sends them MSB byte first as 8N1 UART frames
module wb_trace_uart
   import pu_trace_pkg::*;
#(
   parameter int DW     = 16,
   parameter int DEPTH  = 8,
   parameter int CLKDIV = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          we,
   input  logic [DW-1:0] rwd,
   output logic          txd,
   output logic          busy,
   output logic          ovf,
   output logic [7:0]    drop_cnt
);
   localparam int BW = $clog2(CLKDIV);
   localparam int NB = DW / 8;
   localparam int YW = NB > 1 ? $clog2(NB) : 1;
   tx_state_t            r_state, w_state;
   logic [BW-1:0]        r_baud, w_baud;
   logic [2:0]           r_bit, w_bit;
   logic [YW-1:0]        r_byte, w_byte;
   logic [DW-1:0]        r_sh, w_sh;
   logic                 r_txd, w_txd;
   logic                 r_ovf;
   logic [7:0]           r_drop;
   logic [DW-1:0]        w_dout;
   logic                 w_full, w_empty, w_pop, w_push, w_tick;
   logic [$clog2(DEPTH):0] w_count;
   logic [7:0]           w_cur;
   assign w_pop  = (r_state == IDLE) & ~w_empty;
   assign w_push = we & (~w_full | w_pop);
   assign w_tick = r_baud == '0;
   assign w_cur  = r_sh[DW-1 -: 8];
   trace_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
      .clk(clk), .rst(rst), .push(w_push), .pop(w_pop), .din(rwd),
      .dout(w_dout), .full(w_full), .empty(w_empty), .count(w_count)
   );
   // next-state, baud reload on every state/bit change, shift and line value
   always_comb begin
      w_state = r_state;
      w_baud  = w_tick ? BW'(CLKDIV-1) : r_baud - 1'b1;
      w_bit   = r_bit;
      w_byte  = r_byte;
      w_sh    = r_sh;
      w_txd   = r_txd;
      case (r_state)
         IDLE: if (w_pop) begin
            w_state = START;
            w_sh    = w_dout;
            w_byte  = YW'(NB-1);
            w_txd   = 1'b0;
            w_baud  = BW'(CLKDIV-1);
         end
         START: if (w_tick) begin
            w_state = DATA;
            w_bit   = 3'd0;
            w_txd   = w_cur[0];
         end
         DATA: if (w_tick) begin
            w_state = r_bit == 3'd7 ? STOP : DATA;
            w_bit   = r_bit + 3'd1;
            w_txd   = r_bit == 3'd7 ? 1'b1 : w_cur[r_bit + 3'd1];
         end
         STOP: if (w_tick) begin
            w_state = r_byte != '0 ? START : IDLE;
            w_byte  = r_byte != '0 ? r_byte - 1'b1 : r_byte;
            w_sh    = r_byte != '0 ? r_sh << 8 : r_sh;
            w_txd   = r_byte == '0;
         end
         default: w_state = IDLE;
      endcase
   end
   // state registers plus sticky overflow and saturating drop counter
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         r_state <= IDLE;
         r_baud  <= '0;
         r_bit   <= '0;
         r_byte  <= '0;
         r_sh    <= '0;
         r_txd   <= 1'b1;
         r_ovf   <= 1'b0;
         r_drop  <= '0;
      end else begin
         r_state <= w_state;
         r_baud  <= w_baud;
         r_bit   <= w_bit;
         r_byte  <= w_byte;
         r_sh    <= w_sh;
         r_txd   <= w_txd;
         if (we & ~w_push) begin
            r_ovf  <= 1'b1;
            r_drop <= r_drop == 8'hFF ? r_drop : r_drop + 8'd1;
         end
      end
   assign txd      = r_txd;
   assign busy     = (r_state != IDLE) | (w_count != '0);
   assign ovf      = r_ovf;
   assign drop_cnt = r_drop;
endmodule
